// File: rtl/uart_apb_pkg.sv
// uart_apb_pkg: shared types and defaults for the UART APB4 slave.
// Holds the FSM state enum, bus widths, register window size and timeout.
package uart_apb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    WAIT,
    RESP
  } apb_st_e;

  localparam int          DW          = 32;
  localparam int          APB_AW      = 32;
  localparam logic [31:0] ADDR_RANGE  = 32'h0000_0040;
  localparam int          TIMEOUT_CYC = 16;

endpackage

// File: rtl/uart_apb_timeout_cnt.sv
// uart_apb_timeout_cnt: clear/enable counter with an expiry flag.
// Ports: i_clk, i_rst_n, i_clr, i_en in; o_expired out (high on MAX-th enabled cycle).
module uart_apb_timeout_cnt #(
  parameter int MAX = 16
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expired
);

  localparam int W = (MAX > 1) ? $clog2(MAX) : 1;

  logic [W-1:0] r_cnt;

  // Saturates at expiry so a stalled owner never sees a wrap.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en && !o_expired) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_expired = i_en && (r_cnt == W'(MAX - 1));

endmodule

// File: rtl/uart_apb_slave.sv
// uart_apb_slave: APB4 slave turning each transfer into a one-cycle
// register-block access with wait states until pready_i.
// Ports: APB in (psel/penable/pwrite/pprot/pstrb/paddr/pwdata),
// APB out (prdata/pready/pslverr), reg-block out (wr_en_o/rd_en_o/
// addr_o/wdata_o/strb_o), reg-block in (rdata_i/pready_i).
// Option: define UART_APB_TIMEOUT_EN to bound the wait for pready_i.
module uart_apb_slave #(
  parameter int              DW          = uart_apb_pkg::DW,
  parameter int              APB_AW      = uart_apb_pkg::APB_AW,
  parameter logic [APB_AW-1:0] ADDR_RANGE = APB_AW'(uart_apb_pkg::ADDR_RANGE),
  parameter int              TIMEOUT_CYC = uart_apb_pkg::TIMEOUT_CYC
) (
  input  logic              pclk,
  input  logic              presetn,
  input  logic              psel,
  input  logic              penable,
  input  logic              pwrite,
  input  logic [2:0]        pprot,
  input  logic [DW/8-1:0]   pstrb,
  input  logic [APB_AW-1:0] paddr,
  input  logic [DW-1:0]     pwdata,
  output logic [DW-1:0]     prdata,
  output logic              pready,
  output logic              pslverr,
  output logic              wr_en_o,
  output logic              rd_en_o,
  output logic [APB_AW-1:0] addr_o,
  output logic [DW-1:0]     wdata_o,
  output logic [DW/8-1:0]   strb_o,
  input  logic [DW-1:0]     rdata_i,
  input  logic              pready_i
);

  import uart_apb_pkg::*;

  apb_st_e             r_st;
  apb_st_e             w_nxt;
  logic [DW-1:0]       r_prdata;
  logic                r_pready;
  logic                r_pslverr;
  logic [APB_AW-1:0]   r_addr;
  logic [DW-1:0]       r_wdata;
  logic [DW/8-1:0]     r_strb;
  logic                r_dir;
  logic                w_setup;
  logic                w_dec_err;
  logic                w_nop;
  logic                w_err;
  logic [DW-1:0]       w_rdata;
  logic                w_tmo;
  logic                w_unused;

  assign w_setup   = psel && !penable;
  assign w_dec_err = (paddr[1:0] != 2'b00)
                  || (paddr >= ADDR_RANGE)
                  || (!pwrite && (pstrb != '0));
  // Empty-strobe write is a legal no-op, answered locally.
  assign w_nop     = pwrite && (pstrb == '0) && !w_dec_err;

  // pprot is accepted but not checked.
  assign w_unused  = &{1'b0, pprot, TIMEOUT_CYC[0]};

`ifdef UART_APB_TIMEOUT_EN
  logic w_busy;
  assign w_busy = (r_st == ACCESS) || (r_st == WAIT);

  uart_apb_timeout_cnt #(
    .MAX (TIMEOUT_CYC)
  ) u_tmo (
    .i_clk     (pclk),
    .i_rst_n   (presetn),
    .i_clr     (!w_busy),
    .i_en      (w_busy),
    .o_expired (w_tmo)
  );
`else
  assign w_tmo = 1'b0;
`endif

  always_comb begin
    w_nxt   = r_st;
    w_err   = 1'b0;
    w_rdata = '0;
    unique case (r_st)
      IDLE: begin
        if (w_setup) begin
          unique case (1'b1)
            w_dec_err: begin
              w_nxt = RESP;
              w_err = 1'b1;
            end
            w_nop:   w_nxt = RESP;
            default: w_nxt = ACCESS;
          endcase
        end
      end
      ACCESS, WAIT: begin
        if (!psel) begin
          w_nxt = IDLE;
        end else if (pready_i) begin
          w_nxt = RESP;
          if (!r_dir) w_rdata = rdata_i;
        end else if (w_tmo) begin
          w_nxt = RESP;
          w_err = 1'b1;
        end else begin
          w_nxt = WAIT;
        end
      end
      RESP:    w_nxt = IDLE;
      default: w_nxt = IDLE;
    endcase
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      r_st      <= IDLE;
      r_prdata  <= '0;
      r_pready  <= 1'b0;
      r_pslverr <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_strb    <= '0;
      r_dir     <= 1'b0;
    end else begin
      r_st      <= w_nxt;
      r_pready  <= (w_nxt == RESP);
      r_pslverr <= (w_nxt == RESP) && w_err;
      // prdata only moves on entry to RESP, so aborts leave it intact.
      if (w_nxt == RESP) r_prdata <= w_rdata;
      if (r_st == IDLE && w_setup) begin
        r_addr  <= paddr;
        r_wdata <= pwdata;
        r_strb  <= pstrb;
        r_dir   <= pwrite;
      end
    end
  end

  assign prdata  = r_prdata;
  assign pready  = r_pready;
  assign pslverr = r_pslverr;
  assign addr_o  = r_addr;
  assign wdata_o = r_wdata;
  assign strb_o  = r_strb;
  assign wr_en_o = (r_st == ACCESS) && r_dir;
  assign rd_en_o = (r_st == ACCESS) && !r_dir;

endmodule

// File: tb/tb_uart_apb_slave.sv
// tb_uart_apb_slave: scoreboard bench for the UART APB4 slave.
// Driver pushes expected strobes/responses; negedge monitor pops and checks.
module tb_uart_apb_slave;

  typedef struct {
    logic [31:0] prdata;
    logic        slverr;
    int          lat;
  } rsp_t;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
  } acc_t;

  logic        pclk = 1'b0;
  logic        presetn = 1'b0;
  logic        psel = 1'b0;
  logic        penable = 1'b0;
  logic        pwrite = 1'b0;
  logic [2:0]  pprot = 3'b000;
  logic [3:0]  pstrb = 4'h0;
  logic [31:0] paddr = 32'h0;
  logic [31:0] pwdata = 32'h0;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;
  logic        wr_en_o;
  logic        rd_en_o;
  logic [31:0] addr_o;
  logic [31:0] wdata_o;
  logic [3:0]  strb_o;
  logic [31:0] rdata_i = 32'h0;
  logic        pready_i = 1'b1;

  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   setup_cyc = 0;
  int   rb_delay = 0;
  int   rb_ctr = 0;
  bit   stuck = 1'b0;
  rsp_t rq[$];
  acc_t aq[$];
  rsp_t mon_r;
  acc_t mon_a;

  uart_apb_slave dut (
    .pclk     (pclk),
    .presetn  (presetn),
    .psel     (psel),
    .penable  (penable),
    .pwrite   (pwrite),
    .pprot    (pprot),
    .pstrb    (pstrb),
    .paddr    (paddr),
    .pwdata   (pwdata),
    .prdata   (prdata),
    .pready   (pready),
    .pslverr  (pslverr),
    .wr_en_o  (wr_en_o),
    .rd_en_o  (rd_en_o),
    .addr_o   (addr_o),
    .wdata_o  (wdata_o),
    .strb_o   (strb_o),
    .rdata_i  (rdata_i),
    .pready_i (pready_i)
  );

  always #5 pclk = ~pclk;

  always @(posedge pclk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Register-block model: pready_i rises rb_delay cycles after the strobe.
  always @(negedge pclk) begin
    if (stuck) begin
      pready_i = 1'b0;
    end else if (wr_en_o || rd_en_o) begin
      rb_ctr   = rb_delay;
      pready_i = (rb_delay == 0);
    end else if (rb_ctr > 0) begin
      rb_ctr   = rb_ctr - 1;
      pready_i = (rb_ctr == 0);
    end else begin
      pready_i = 1'b1;
    end
  end

  // Monitor
  always @(negedge pclk) begin
    if (pready) begin
      if (rq.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexp_pready: got pready=1 want none at cyc %0d", cyc);
      end else begin
        mon_r = rq.pop_front();
        chk("prdata", prdata, mon_r.prdata);
        chk("pslverr", 32'(pslverr), 32'(mon_r.slverr));
        chk("latency", cyc - setup_cyc, mon_r.lat);
      end
    end
    if (wr_en_o || rd_en_o) begin
      if (aq.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexp_strobe: got wr=%0b rd=%0b want none",
                 wr_en_o, rd_en_o);
      end else begin
        mon_a = aq.pop_front();
        chk("wr_en", 32'(wr_en_o), 32'(mon_a.wr));
        chk("rd_en", 32'(rd_en_o), 32'(!mon_a.wr));
        chk("addr_o", addr_o, mon_a.addr);
        chk("wdata_o", wdata_o, mon_a.wdata);
        chk("strb_o", 32'(strb_o), 32'(mon_a.strb));
      end
    end
  end

  task automatic exp_rsp(input logic [31:0] d, input logic e, input int l);
    rsp_t r;
    r.prdata = d;
    r.slverr = e;
    r.lat    = l;
    rq.push_back(r);
  endtask

  task automatic exp_acc(input logic w, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] s);
    acc_t x;
    x.wr    = w;
    x.addr  = a;
    x.wdata = d;
    x.strb  = s;
    aq.push_back(x);
  endtask

  task automatic start(input logic w, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] s);
    @(posedge pclk);
    #1;
    psel    = 1'b1;
    penable = 1'b0;
    pwrite  = w;
    paddr   = a;
    pwdata  = d;
    pstrb   = s;
    pprot   = 3'b010;
    @(posedge pclk);
    #1;
    setup_cyc = cyc;
    penable   = 1'b1;
  endtask

  task automatic wait_rsp(input string nm);
    bit got;
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge pclk);
      if (pready) got = 1'b1;
    end
    if (!got) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s: got no pready want pready within 40 cycles", nm);
    end
  endtask

  task automatic go_idle();
    @(posedge pclk);
    #1;
    psel    = 1'b0;
    penable = 1'b0;
  endtask

  initial begin
    repeat (2) @(negedge pclk);
    chk("rst_prdata", prdata, 32'h0);
    chk("rst_pready", 32'(pready), 32'h0);
    chk("rst_pslverr", 32'(pslverr), 32'h0);
    chk("rst_wr_en", 32'(wr_en_o), 32'h0);
    chk("rst_rd_en", 32'(rd_en_o), 32'h0);
    chk("rst_addr", addr_o, 32'h0);
    chk("rst_wdata", wdata_o, 32'h0);
    chk("rst_strb", 32'(strb_o), 32'h0);
    @(posedge pclk);
    #1;
    presetn = 1'b1;

    // Write, zero-delay register block
    rb_delay = 0;
    exp_acc(1'b1, 32'h08, 32'hA5, 4'hF);
    exp_rsp(32'h0, 1'b0, 1);
    start(1'b1, 32'h08, 32'hA5, 4'hF);
    wait_rsp("wr08");
    go_idle();

    // Read with three extra wait states
    rb_delay = 3;
    rdata_i  = 32'h1234;
    exp_acc(1'b0, 32'h04, 32'h0, 4'h0);
    exp_rsp(32'h1234, 1'b0, 4);
    start(1'b0, 32'h04, 32'h0, 4'h0);
    wait_rsp("rd04");
    go_idle();

    // Decode errors and no-op write
    rb_delay = 0;
    exp_rsp(32'h0, 1'b1, 0);
    start(1'b0, 32'h06, 32'h0, 4'h0);
    wait_rsp("rd06");
    go_idle();
    exp_rsp(32'h0, 1'b1, 0);
    start(1'b0, 32'h40, 32'h0, 4'h0);
    wait_rsp("rd40");
    go_idle();
    exp_rsp(32'h0, 1'b0, 0);
    start(1'b1, 32'h0C, 32'h5A, 4'h0);
    wait_rsp("wr_nop");
    go_idle();
    exp_rsp(32'h0, 1'b1, 0);
    start(1'b0, 32'h00, 32'h0, 4'h1);
    wait_rsp("rd_strb");
    go_idle();
    exp_rsp(32'h0, 1'b1, 0);
    start(1'b1, 32'h01, 32'h11, 4'hF);
    wait_rsp("wr01");
    go_idle();

    // Back-to-back: top word read, write, read
    rdata_i = 32'hDEAD_BEEF;
    exp_acc(1'b0, 32'h3C, 32'h0, 4'h0);
    exp_rsp(32'hDEAD_BEEF, 1'b0, 1);
    start(1'b0, 32'h3C, 32'h0, 4'h0);
    wait_rsp("rd3c");
    rb_delay = 1;
    exp_acc(1'b1, 32'h10, 32'h55AA, 4'h3);
    exp_rsp(32'h0, 1'b0, 2);
    start(1'b1, 32'h10, 32'h55AA, 4'h3);
    wait_rsp("wr10");
    rb_delay = 0;
    rdata_i  = 32'hCAFE_0001;
    exp_acc(1'b0, 32'h14, 32'h0, 4'h0);
    exp_rsp(32'hCAFE_0001, 1'b0, 1);
    start(1'b0, 32'h14, 32'h0, 4'h0);
    wait_rsp("rd14");
    go_idle();

    // Abort during WAIT: no pready, prdata/pslverr unchanged
    stuck = 1'b1;
    exp_acc(1'b0, 32'h20, 32'h0, 4'h0);
    start(1'b0, 32'h20, 32'h0, 4'h0);
    repeat (3) @(negedge pclk);
    go_idle();
    repeat (3) @(negedge pclk);
    chk("abort_prdata", prdata, 32'hCAFE_0001);
    chk("abort_pslverr", 32'(pslverr), 32'h0);
    stuck = 1'b0;

    // Reset during WAIT
    stuck = 1'b1;
    exp_acc(1'b0, 32'h24, 32'h99, 4'h0);
    start(1'b0, 32'h24, 32'h99, 4'h0);
    repeat (2) @(negedge pclk);
    #2;
    presetn = 1'b0;
    #1;
    chk("mrst_prdata", prdata, 32'h0);
    chk("mrst_pready", 32'(pready), 32'h0);
    chk("mrst_pslverr", 32'(pslverr), 32'h0);
    chk("mrst_addr", addr_o, 32'h0);
    chk("mrst_wdata", wdata_o, 32'h0);
    chk("mrst_rd_en", 32'(rd_en_o), 32'h0);
    @(posedge pclk);
    #1;
    psel    = 1'b0;
    penable = 1'b0;
    stuck   = 1'b0;
    presetn = 1'b1;

    // Normal transfer after reset
    exp_acc(1'b1, 32'h18, 32'h77, 4'hF);
    exp_rsp(32'h0, 1'b0, 1);
    start(1'b1, 32'h18, 32'h77, 4'hF);
    wait_rsp("wr18");
    go_idle();

`ifdef UART_APB_TIMEOUT_EN
    // Register block never answers
    stuck = 1'b1;
    exp_acc(1'b0, 32'h28, 32'h0, 4'h0);
    exp_rsp(32'h0, 1'b1, 16);
    start(1'b0, 32'h28, 32'h0, 4'h0);
    wait_rsp("tmo28");
    go_idle();
    stuck = 1'b0;
`endif

    repeat (4) @(negedge pclk);
    chk("rsp_queue_empty", rq.size(), 32'h0);
    chk("acc_queue_empty", aq.size(), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_apb_slave.md
# uart_apb_slave

APB4 slave front-end of the UART IP: terminates the APB bus driven by the system master and converts each transfer into a single-cycle register-file access (write or read strobe, address, data, byte strobes). It sits directly between the APB bus and the UART register block. It returns `prdata`/`pready`/`pslverr` with wait states inserted until the register block signals completion. Decode errors are answered locally without touching the register block.

## Interface
- `DW`, 32, data width (fixed 32; `pstrb` is DW/8).
- `APB_AW`, 32, APB address width.
- `ADDR_RANGE`, 32'h0000_0040, byte size of the UART register window; `paddr >= ADDR_RANGE` is a decode error.
- `TIMEOUT_CYC`, 16, maximum wait cycles for `pready_i` (used only with the timeout feature).

Ports:
- `pclk` in 1: single clock, all logic on rising edge.
- `presetn` in 1: asynchronous, active-low reset.
- `psel` in 1, `penable` in 1, `pwrite` in 1, `pprot` in 3, `pstrb` in 4, `paddr` in APB_AW, `pwdata` in DW: APB request.
- `prdata` out DW, `pready` out 1, `pslverr` out 1: APB response.
- `wr_en_o` out 1, `rd_en_o` out 1: one-cycle access strobes to the register block.
- `addr_o` out APB_AW, `wdata_o` out DW, `strb_o` out 4: latched access fields.
- `rdata_i` in DW, `pready_i` in 1: register-block read data and completion.

## Operation
- FSM states:
  - IDLE → ACCESS when `psel && !penable` is sampled and the request decodes cleanly.
  - IDLE → RESP directly when the request has a decode error.
  - ACCESS (1 cycle, strobe high) → WAIT, or → RESP if `pready_i` is already high.
  - WAIT → RESP on `pready_i`.
  - RESP → IDLE unconditionally.
- Decode error (any one raises `pslverr`):
  - `paddr[1:0] != 0`.
  - `paddr >= ADDR_RANGE`.
  - Read with `pstrb != 0`.
- Write with `pstrb == 0`: no `wr_en_o`, goes to RESP with `pslverr = 0` (legal no-op).
- Capture: on the setup edge, latch `paddr`, `pwdata`, `pstrb` and `pwrite` into `addr_o`, `wdata_o`, `strb_o` and an internal direction bit. These hold until the next setup.
- Strobes: `wr_en_o` or `rd_en_o` is high only in ACCESS. Exactly one of them pulses per legal access; neither pulses for an error or no-op.
- Read data: on a read, `prdata` loads `rdata_i` on the edge where `pready_i` is sampled. `prdata` is 0 for writes and errors and holds until the next response.
- Response: `pready` and `pslverr` are registered and high only in RESP.
- `pprot` is ignored (accepted, not checked).
- Abort: if `psel` is sampled low in ACCESS or WAIT, go to IDLE. No `pready` is issued; `prdata` and `pslverr` are unchanged.
- Protocol violation: `penable` high while in IDLE is ignored (no transfer starts).

## Timing
- Reset values: `prdata`=0, `pready`=0, `pslverr`=0, `wr_en_o`=0, `rd_en_o`=0, `addr_o`=0, `wdata_o`=0, `strb_o`=0; FSM in IDLE.
- Reset mid-transfer: all of the above clear immediately (asynchronous); the in-flight access is lost.
- Minimum latency (`pready_i` high during ACCESS): setup at edge 0, ACCESS in cycle 0–1, RESP in cycle 1–2. One APB wait state; transfer completes at edge 2.
- Each extra cycle of `pready_i` low adds one wait state.
- Error or no-op: RESP in cycle 0–1, so the access phase has zero wait states.
- Back-to-back: a new setup sampled at the edge leaving RESP is accepted, because IDLE evaluates the request in the same cycle.

## Configuration
- `UART_APB_TIMEOUT_EN` defined:
  - A counter runs in ACCESS and WAIT and resets on leaving them.
  - When it reaches `TIMEOUT_CYC` with `pready_i` still low, go to RESP with `pslverr = 1` and `prdata = 0`.
  - A late `pready_i` after timeout is ignored.
- Undefined: WAIT persists indefinitely until `pready_i` or abort; the counter logic is absent.

## Structure
- Package `uart_apb_pkg`:
  - state enum `apb_st_e` (IDLE, ACCESS, WAIT, RESP);
  - `DW` and `APB_AW` defaults;
  - `ADDR_RANGE`, `TIMEOUT_CYC`.
- One sub-module, `uart_apb_timeout_cnt`: a clear/enable counter with an expiry flag. It is instantiated only under `UART_APB_TIMEOUT_EN`.

## Test plan
- Write `paddr`=0x08, `pwdata`=0xA5, `pstrb`=4'hF, `pready_i` tied high → `wr_en_o` one pulse with `addr_o`=0x08, `wdata_o`=0xA5; `pready` at edge 2; `pslverr`=0.
- Read `paddr`=0x04, `pstrb`=0, `pready_i` delayed 3 cycles, `rdata_i`=0x1234 → one `rd_en_o` pulse, 3 extra wait states, `prdata`=0x1234, `pslverr`=0.
- Read `paddr`=0x06, then read `paddr`=0x40 → no strobes; each gets `pready` with `pslverr`=1 one cycle after setup; `prdata`=0.
- Write with `pstrb`=0 → no `wr_en_o`; `pready`=1 and `pslverr`=0 one cycle after setup.
- Assert `presetn`=0 during WAIT → all outputs 0 immediately; the next transfer after reset completes normally.
- With `UART_APB_TIMEOUT_EN` and `pready_i` stuck low → `pslverr`=1 after `TIMEOUT_CYC`=16 wait cycles; `prdata`=0.
